// File: rtl/tsched_pkg.sv
// Shared types and constants for the timestamp event scheduler.
//   tsched_state_t : controller FSM state, encoded as reported on state_o
//   TS_W_DEF       : default timestamp width (12 BCD digits)
//   N_CH_MAX       : largest supported channel count
//   ch_width()     : width of a channel index, never less than 1 bit
package tsched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StRun   = 2'd2,
    StDrain = 2'd3
  } tsched_state_t;

  localparam int unsigned TS_W_DEF = 48;
  localparam int unsigned N_CH_MAX = 8;

  function automatic int unsigned ch_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: returns the first requesting channel at or after ptr, wrapping cyclically.
//   req   : request vector, one bit per channel
//   ptr   : channel with highest priority this cycle
//   grant : chosen channel index (0 when nothing requests)
//   any   : at least one request present
module rr_arbiter #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] grant,
  output logic            any
);

  logic [CH_W-1:0] hi_idx, lo_idx;
  logic            hi_any, lo_any;

  // Walk downwards so the last hit is the lowest index: lo_* is the lowest request overall,
  // hi_* the lowest request at or above ptr. Falling back to lo_* provides the wrap.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    lo_any = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = CH_W'(i);
        lo_any = 1'b1;
        if (CH_W'(i) >= ptr) begin
          hi_idx = CH_W'(i);
          hi_any = 1'b1;
        end
      end
    end
    grant = hi_any ? hi_idx : lo_idx;
    any   = lo_any;
  end

endmodule

// File: rtl/timestamp_event_scheduler.sv
// Stopwatch controller and trigger-timestamp arbiter.
// Sequences the stopwatch through IDLE/CLEAR/RUN/DRAIN, latches ts_in on each rising trigger
// edge per channel, and round-robins pending channels onto one valid/ready event stream.
//   clk, reset (async, active-low)
//   cmd_start / cmd_stop / cmd_clear : one-cycle command pulses
//   ts_in, trig                      : stopwatch value, synchronous trigger levels
//   tm_clear                         : stopwatch reset, high in IDLE and CLEAR
//   evt_valid/evt_ready/evt_ch/evt_ts: event stream
//   evt_count                        : events accepted since last CLEAR (wraps)
//   lost_any                         : sticky, a trigger edge was dropped
//   state_o                          : FSM state
module timestamp_event_scheduler
  import tsched_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned TS_W       = TS_W_DEF,
  parameter int unsigned CLR_CYCLES = 2,
  localparam int unsigned CH_W      = ch_width(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_start,
  input  logic            cmd_stop,
  input  logic            cmd_clear,
  input  logic [TS_W-1:0] ts_in,
  input  logic [N_CH-1:0] trig,
  output logic            tm_clear,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic [TS_W-1:0] evt_ts,
  output logic [31:0]     evt_count,
  output logic            lost_any,
  output logic [1:0]      state_o
);

  tsched_state_t   state_q, state_d;
  logic [3:0]      clr_cnt_q, clr_cnt_d;
  logic [N_CH-1:0] trig_q, pending_q, pending_d;
  logic [N_CH-1:0] rise, accept, drop, unload;
  logic [TS_W-1:0] ts_reg_q [N_CH];
  logic            evt_valid_q;
  logic [CH_W-1:0] evt_ch_q, rr_ptr_q;
  logic [TS_W-1:0] evt_ts_q;
  logic [31:0]     evt_count_q, count_inc;
  logic            lost_any_q;
  logic            load, flush, capture_en;
  logic [CH_W-1:0] grant;
  logic            any;

  rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_rr_arbiter (
    .req   (pending_q),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .any   (any)
  );

  // Priority clear > stop > start; commands not meaningful in a state are ignored.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = '0;
    unique case (state_q)
      StIdle: begin
        if (cmd_clear || cmd_start) state_d = StClear;
      end
      StClear: begin
        clr_cnt_d = clr_cnt_q + 4'd1;
        if (clr_cnt_q == 4'(CLR_CYCLES - 1)) state_d = StRun;
      end
      StRun: begin
        if (cmd_clear)      state_d = StClear;
        else if (cmd_stop)  state_d = StDrain;
        else if (cmd_start) state_d = StClear;
      end
      StDrain: begin
        if (cmd_clear)                  state_d = StClear;
        else if (cmd_start && !cmd_stop) state_d = StClear;
        else if (pending_q == '0 && (!evt_valid_q || evt_ready)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Flushing on the entry edge too makes evt_valid drop the cycle after a clear command.
  assign flush      = (state_d == StClear);
  assign capture_en = (state_q == StRun) && !flush;
  assign load       = !evt_valid_q || evt_ready;

  always_comb begin
    rise   = trig & ~trig_q;
    unload = '0;
    if (load && any) unload[grant] = 1'b1;
    // A channel being unloaded this cycle can take a new edge: old value leaves, new one lands.
    accept    = capture_en ? (rise & (~pending_q | unload)) : '0;
    drop      = capture_en ? (rise & pending_q & ~unload) : '0;
    pending_d = flush ? '0 : ((pending_q & ~unload) | accept);
    count_inc = '0;
    for (int i = 0; i < N_CH; i++) count_inc = count_inc + 32'(accept[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      clr_cnt_q   <= '0;
      trig_q      <= '0;
      pending_q   <= '0;
      for (int i = 0; i < N_CH; i++) ts_reg_q[i] <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_ts_q    <= '0;
      rr_ptr_q    <= '0;
      evt_count_q <= '0;
      lost_any_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      trig_q    <= trig;
      pending_q <= pending_d;
      for (int i = 0; i < N_CH; i++) begin
        if (accept[i]) ts_reg_q[i] <= ts_in;
      end
      if (flush) begin
        evt_count_q <= '0;
        lost_any_q  <= 1'b0;
        evt_valid_q <= 1'b0;
      end else begin
        evt_count_q <= evt_count_q + count_inc;
        if (|drop) lost_any_q <= 1'b1;
        if (load) begin
          evt_valid_q <= any;
          if (any) begin
            evt_ch_q <= grant;
            evt_ts_q <= ts_reg_q[grant];
            rr_ptr_q <= (grant == CH_W'(N_CH - 1)) ? '0 : grant + CH_W'(1);
          end
        end
      end
    end
  end

  assign tm_clear  = (state_q == StIdle) || (state_q == StClear);
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_ts    = evt_ts_q;
  assign evt_count = evt_count_q;
  assign lost_any  = lost_any_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_timestamp_event_scheduler.sv
module tb_timestamp_event_scheduler;

  logic        clk;
  logic        reset;
  logic        cmd_start, cmd_stop, cmd_clear;
  logic [47:0] ts_in;
  logic [3:0]  trig;
  logic        tm_clear;
  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_ch;
  logic [47:0] evt_ts;
  logic [31:0] evt_count;
  logic        lost_any;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  timestamp_event_scheduler #(
    .N_CH       (4),
    .TS_W       (48),
    .CLR_CYCLES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_start (cmd_start),
    .cmd_stop  (cmd_stop),
    .cmd_clear (cmd_clear),
    .ts_in     (ts_in),
    .trig      (trig),
    .tm_clear  (tm_clear),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_ts    (evt_ts),
    .evt_count (evt_count),
    .lost_any  (lost_any),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0;
    ts_in = '0; trig = '0; evt_ready = 1'b1;
    tick(); tick();
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_tm_clear", 64'(tm_clear), 64'd1);
    chk("rst_valid", 64'(evt_valid), 64'd0);
    chk("rst_ch", 64'(evt_ch), 64'd0);
    chk("rst_ts", 64'(evt_ts), 64'd0);
    chk("rst_count", 64'(evt_count), 64'd0);
    chk("rst_lost", 64'(lost_any), 64'd0);
    reset = 1'b1;
    tick();

    // start: two CLEAR cycles then RUN
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    chk("start_clr1_state", 64'(state_o), 64'd1);
    chk("start_clr1_tm", 64'(tm_clear), 64'd1);
    tick();
    chk("start_clr2_state", 64'(state_o), 64'd1);
    chk("start_clr2_tm", 64'(tm_clear), 64'd1);
    tick();
    chk("start_run_state", 64'(state_o), 64'd2);
    chk("start_run_tm", 64'(tm_clear), 64'd0);
    chk("start_run_valid", 64'(evt_valid), 64'd0);

    // four simultaneous edges, pointer at 0
    ts_in = 48'h999; trig = 4'hF; tick(); trig = 4'h0;
    chk("sim4a_t1_valid", 64'(evt_valid), 64'd0);
    chk("sim4a_count", 64'(evt_count), 64'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sim4a_valid", 64'(evt_valid), 64'd1);
      chk("sim4a_ch", 64'(evt_ch), 64'(k));
      chk("sim4a_ts", 64'(evt_ts), 64'h999);
    end
    tick();
    chk("sim4a_empty", 64'(evt_valid), 64'd0);

    // single edge on ch2, latency t+2
    ts_in = 48'h000000000123; trig = 4'b0100; tick(); trig = 4'h0;
    chk("ch2_t1_valid", 64'(evt_valid), 64'd0);
    tick();
    chk("ch2_valid", 64'(evt_valid), 64'd1);
    chk("ch2_ch", 64'(evt_ch), 64'd2);
    chk("ch2_ts", 64'(evt_ts), 64'h123);
    chk("ch2_count", 64'(evt_count), 64'd5);
    tick();
    chk("ch2_empty", 64'(evt_valid), 64'd0);

    // ch1 alone moves the pointer to 2
    ts_in = 48'h55; trig = 4'b0010; tick(); trig = 4'h0; tick();
    chk("ch1_ch", 64'(evt_ch), 64'd1);
    chk("ch1_count", 64'(evt_count), 64'd6);
    tick();

    // four simultaneous edges, pointer at 2: order 2,3,0,1
    ts_in = 48'h777; trig = 4'hF; tick(); trig = 4'h0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sim4b_ch", 64'(evt_ch), 64'((k + 2) % 4));
      chk("sim4b_ts", 64'(evt_ts), 64'h777);
    end
    chk("sim4b_count", 64'(evt_count), 64'd10);
    tick();
    chk("sim4b_empty", 64'(evt_valid), 64'd0);

    // backpressure: held output, second edge goes pending, third edge is dropped
    evt_ready = 1'b0;
    ts_in = 48'hAAA; trig = 4'b0010; tick(); trig = 4'h0; tick();
    chk("bp_valid", 64'(evt_valid), 64'd1);
    chk("bp_ts", 64'(evt_ts), 64'hAAA);
    chk("bp_count1", 64'(evt_count), 64'd11);
    tick(); tick();
    chk("bp_hold_ch", 64'(evt_ch), 64'd1);
    chk("bp_hold_ts", 64'(evt_ts), 64'hAAA);
    ts_in = 48'hBBB; trig = 4'b0010; tick(); trig = 4'h0;
    chk("bp_count2", 64'(evt_count), 64'd12);
    chk("bp_lost0", 64'(lost_any), 64'd0);
    tick();
    ts_in = 48'hCCC; trig = 4'b0010; tick(); trig = 4'h0;
    chk("bp_lost1", 64'(lost_any), 64'd1);
    chk("bp_count3", 64'(evt_count), 64'd12);
    chk("bp_ts_kept", 64'(evt_ts), 64'hAAA);
    chk("bp_valid_kept", 64'(evt_valid), 64'd1);
    evt_ready = 1'b1; tick();
    chk("bp_second_ch", 64'(evt_ch), 64'd1);
    chk("bp_second_ts", 64'(evt_ts), 64'hBBB);
    tick();
    chk("bp_empty", 64'(evt_valid), 64'd0);

    // stop and drain: three events out, post-stop edge ignored, then IDLE
    evt_ready = 1'b0;
    ts_in = 48'h321; trig = 4'b0111; tick(); trig = 4'h0;
    chk("dr_count", 64'(evt_count), 64'd15);
    tick();
    chk("dr_first_ch", 64'(evt_ch), 64'd2);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    chk("dr_state", 64'(state_o), 64'd3);
    ts_in = 48'h444; trig = 4'b1000; tick(); trig = 4'h0;
    chk("dr_ignored_count", 64'(evt_count), 64'd15);
    evt_ready = 1'b1; tick();
    chk("dr_second_ch", 64'(evt_ch), 64'd0);
    chk("dr_second_ts", 64'(evt_ts), 64'h321);
    tick();
    chk("dr_third_ch", 64'(evt_ch), 64'd1);
    chk("dr_third_valid", 64'(evt_valid), 64'd1);
    tick();
    chk("dr_idle_state", 64'(state_o), 64'd0);
    chk("dr_idle_valid", 64'(evt_valid), 64'd0);
    chk("dr_idle_tm", 64'(tm_clear), 64'd1);

    // restart flushes count and lost flag
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    chk("rs_count", 64'(evt_count), 64'd0);
    chk("rs_lost", 64'(lost_any), 64'd0);
    tick(); tick();
    chk("rs_state", 64'(state_o), 64'd2);

    // clear with an event held and one pending
    evt_ready = 1'b0;
    ts_in = 48'h0AB; trig = 4'b0011; tick(); trig = 4'h0; tick();
    chk("cl_ch", 64'(evt_ch), 64'd0);
    chk("cl_pre_count", 64'(evt_count), 64'd2);
    trig = 4'b0010; tick(); trig = 4'h0;
    chk("cl_pre_lost", 64'(lost_any), 64'd1);
    tick();
    cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    chk("cl_valid", 64'(evt_valid), 64'd0);
    chk("cl_count", 64'(evt_count), 64'd0);
    chk("cl_lost", 64'(lost_any), 64'd0);
    chk("cl_state1", 64'(state_o), 64'd1);
    tick();
    chk("cl_state2", 64'(state_o), 64'd1);
    chk("cl_tm2", 64'(tm_clear), 64'd1);
    tick();
    chk("cl_run", 64'(state_o), 64'd2);
    chk("cl_run_tm", 64'(tm_clear), 64'd0);
    tick();
    chk("cl_flushed", 64'(evt_valid), 64'd0);

    // asynchronous reset mid-operation
    ts_in = 48'h5A; trig = 4'b0001; tick(); trig = 4'h0; tick();
    chk("ar_pre_valid", 64'(evt_valid), 64'd1);
    chk("ar_pre_count", 64'(evt_count), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_state", 64'(state_o), 64'd0);
    chk("ar_valid", 64'(evt_valid), 64'd0);
    chk("ar_count", 64'(evt_count), 64'd0);
    chk("ar_ts", 64'(evt_ts), 64'd0);
    chk("ar_tm", 64'(tm_clear), 64'd1);
    tick();
    reset = 1'b1;
    tick(); tick();
    chk("ar_after_valid", 64'(evt_valid), 64'd0);
    chk("ar_after_state", 64'(state_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
